multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle successor to the single-cycle RV32I decoder: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles. It handshakes with instruction and data memories that may insert wait states, and detects illegal encodings and memory timeouts. It sits between the datapath (IR, PC, register file, ALU, data memory) and drives all of their enables.

## Interface
- `ALUCTL_W`, default 4: ALU control width, ≥4; codes are zero-extended.
- `TIMEOUT`, default 15: maximum wait cycles on a memory handshake before a fault; range 1..255.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `inst` in 32: instruction from datapath IR, valid from DECODE onward.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access complete.
- `alu_zero` in 1: ALU result == 0.
- `alu_lsb` in 1: ALU result bit 0.
- `ALUControl` out `ALUCTL_W`: ALU operation.
- `regwe`, `dmemwe`, `regsel`, `rs2sel` out 1 each: same meaning as the single-cycle controller (regsel 1 = memory to rd; rs2sel 1 = immediate).
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `ir_we` out 1: load IR.
- `pc_we` out 1: update PC.
- `pc_sel` out 1: 0 = PC+4, 1 = PC+imm.
- `illegal` out 1: sticky illegal-instruction flag.
- `fault` out 1: sticky memory-timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset enters IDLE. IDLE always goes to FETCH on the next cycle.
- **FETCH**: `imem_req`=1.
  - On `imem_ready`: `ir_we`=1 and go to DECODE.
  - Otherwise the wait counter increments.
- **DECODE**: decode `inst`.
  - Unsupported opcode, funct3 or funct7 → TRAP with `illegal`=1.
  - Supported → EXEC.
- **EXEC**: `ALUControl`/`rs2sel` are driven.
  - R/I-type → WB.
  - Load/store → MEM.
  - Branch (when `BRANCH_EN` is compiled in) → FETCH, with `pc_we`=1 and `pc_sel`=taken.
- **MEM**: `dmem_req`=1, `ALUControl`=ADD, `rs2sel`=1; stores also hold `dmemwe`=1.
  - Load: on `dmem_ready` → WB.
  - Store: on `dmem_ready`, `pc_we`=1 → FETCH.
- **WB**: `regwe`=1 for one cycle, `pc_we`=1, `pc_sel`=0; loads have `regsel`=1. Next state is FETCH.
- **ALU codes**: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLTU 1001, SLT 1010.
- **Decoded set**:
  - R-type: all ten operations.
  - I-type ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI (shifts check funct7).
  - Loads: LB, LH, LW, LBU, LHU.
  - Stores: SB, SH, SW.
- **Timeout**: the 8-bit wait counter clears on entry to FETCH and to MEM. If it reaches `TIMEOUT` without ready → TRAP, `fault`=1. Ready arriving in the same cycle the count reaches `TIMEOUT` counts as success.
- **TRAP**: all enables and requests are 0. The block stays in TRAP until reset.
- Every output is 0 in any state where it is not listed.

## Timing
- State and the wait counter are registered. Outputs are combinational from state and `inst` only, never from `*_ready`, except `ir_we` and `pc_we`, which are qualified by ready.
- Reset value of every output is 0; `illegal`=0 and `fault`=0.
- Reset asserted mid-instruction aborts immediately. No write enable may be seen after the reset edge.
- Latency with zero wait states (ready in the first cycle):
  - ALU instruction: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each extra wait cycle adds one cycle.
- `regwe` and `dmemwe` never assert in the same cycle.

## Configuration
- `MULTICYCLE_BRANCH_EN` defined:
  - Opcode 1100011 is decoded.
  - BEQ/BNE use SUB; taken = `alu_zero` / !`alu_zero`.
  - BLT/BGE use SLT; BLTU/BGEU use SLTU; taken = `alu_lsb` / !`alu_lsb`.
  - funct3 010/011 → illegal.
- `MULTICYCLE_BRANCH_EN` undefined: opcode 1100011 is illegal, and `pc_sel` is tied to 0.

## Test plan
- Reset, then `inst`=0x002081B3 (ADD x3,x1,x2) with ready always 1 → IR load, DECODE, EXEC with `ALUControl`=0000, then WB with `regwe`=1 and `pc_we`=1; 4 cycles, then FETCH again.
- LW 0x0000A183 with `dmem_ready` delayed 3 cycles → MEM held 4 cycles with `dmem_req`=1 and `dmemwe`=0; WB with `regsel`=1; total 8 cycles.
- SW 0x0030A023 → MEM with `dmemwe`=1 and `rs2sel`=1; `regwe` stays 0 throughout; `pc_we` pulses on `dmem_ready`.
- `inst`=0xFFFFFFFF → TRAP, `illegal`=1, no enable ever asserted; stays there until `reset` low.
- `imem_ready` held 0 with `TIMEOUT`=15 → `fault`=1 on cycle 15 of FETCH. A separate run with ready arriving on cycle 15 → no fault.
- With `MULTICYCLE_BRANCH_EN`: BNE 0x00209463 with `alu_zero`=0 → `pc_we`=1 and `pc_sel`=1 in EXEC. Without the macro: the same instruction → `illegal`=1.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle RV32I controller.
// master : the controller (consumes IR/handshakes/ALU flags, drives enables).
// slave  : the datapath and memories.
// Signals:
//   inst        IR contents, valid from DECODE onward
//   imem_ready  instruction memory data valid
//   dmem_ready  data memory access complete
//   alu_zero    ALU result == 0
//   alu_lsb     ALU result bit 0
//   ALUControl  ALU operation (zero-extended 4-bit code)
//   regwe/dmemwe/regsel/rs2sel  register-file / data-memory / mux controls
//   imem_req/dmem_req           memory requests
//   ir_we/pc_we/pc_sel          IR load, PC update, PC source (0 = PC+4)
//   illegal/fault               sticky illegal-instruction / memory-timeout flags
interface multicycle_controller_if #(
  parameter int unsigned ALUCTL_W = 4
);
  logic [31:0]         inst;
  logic                imem_ready;
  logic                dmem_ready;
  logic                alu_zero;
  logic                alu_lsb;
  logic [ALUCTL_W-1:0] ALUControl;
  logic                regwe;
  logic                dmemwe;
  logic                regsel;
  logic                rs2sel;
  logic                imem_req;
  logic                dmem_req;
  logic                ir_we;
  logic                pc_we;
  logic                pc_sel;
  logic                illegal;
  logic                fault;

  modport master (
    input  inst, imem_ready, dmem_ready, alu_zero, alu_lsb,
    output ALUControl, regwe, dmemwe, regsel, rs2sel,
           imem_req, dmem_req, ir_we, pc_we, pc_sel, illegal, fault
  );

  modport slave (
    output inst, imem_ready, dmem_ready, alu_zero, alu_lsb,
    input  ALUControl, regwe, dmemwe, regsel, rs2sel,
           imem_req, dmem_req, ir_we, pc_we, pc_sel, illegal, fault
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I controller: Moore FSM sequencing FETCH, DECODE, EXEC,
// MEM and WB with wait-state tolerant memory handshakes, illegal-encoding
// detection and memory-timeout detection. TRAP is terminal until reset.
// Optional feature macro: MULTICYCLE_BRANCH_EN (conditional branches).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    multicycle_controller_if.master (IR, handshakes, ALU flags in;
//          datapath enables, requests and sticky flags out)
// Outputs are combinational from state and IR; only ir_we and pc_we (in MEM)
// are additionally qualified by the memory ready inputs.
module multicycle_controller #(
  parameter int unsigned ALUCTL_W = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic                      clk,
  input logic                      reset,
  multicycle_controller_if.master  bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 7;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_ILL, C_R, C_I, C_LOAD, C_STORE, C_BRANCH
  } cls_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;

  logic [31:0]      inst;
  logic [OP_W-1:0]  opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  cls_e             cls;
  logic [3:0]       alu_code;
  logic             br_taken;
  logic [CNT_W-1:0] wait_inc;
  logic             wait_expired;
  logic             unused_bits;

  logic [3:0]       alu_c;
  logic             regwe_c, dmemwe_c, regsel_c, rs2sel_c;
  logic             imem_req_c, dmem_req_c, ir_we_c, pc_we_c, pc_sel_c;

  assign inst   = bus.inst;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register indices and immediates belong to the datapath.
`ifdef MULTICYCLE_BRANCH_EN
  assign unused_bits = ^{inst[24:15], inst[11:7]};
`else
  assign unused_bits = ^{inst[24:15], inst[11:7], bus.alu_zero, bus.alu_lsb};
`endif

  // Instruction class, ALU operation and branch outcome from the IR.
  always_comb begin
    cls      = C_ILL;
    alu_code = ALU_ADD;
    br_taken = 1'b0;
    case (opcode)
      OP_R: begin
        cls = C_R;
        case ({funct7, funct3})
          {7'h00, 3'b000}: alu_code = ALU_ADD;
          {7'h20, 3'b000}: alu_code = ALU_SUB;
          {7'h00, 3'b001}: alu_code = ALU_SLL;
          {7'h00, 3'b010}: alu_code = ALU_SLT;
          {7'h00, 3'b011}: alu_code = ALU_SLTU;
          {7'h00, 3'b100}: alu_code = ALU_XOR;
          {7'h00, 3'b101}: alu_code = ALU_SRL;
          {7'h20, 3'b101}: alu_code = ALU_SRA;
          {7'h00, 3'b110}: alu_code = ALU_OR;
          {7'h00, 3'b111}: alu_code = ALU_AND;
          default:         cls      = C_ILL;
        endcase
      end
      OP_I: begin
        cls = C_I;
        case (funct3)
          3'b000: alu_code = ALU_ADD;
          3'b010: alu_code = ALU_SLT;
          3'b011: alu_code = ALU_SLTU;
          3'b100: alu_code = ALU_XOR;
          3'b110: alu_code = ALU_OR;
          3'b111: alu_code = ALU_AND;
          // Shift-immediates reuse funct7 as an encoding qualifier.
          3'b001: begin
            alu_code = ALU_SLL;
            if (funct7 != 7'h00) cls = C_ILL;
          end
          default: begin
            if (funct7 == 7'h00)      alu_code = ALU_SRL;
            else if (funct7 == 7'h20) alu_code = ALU_SRA;
            else                      cls      = C_ILL;
          end
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) cls = C_ILL;
        else                                                           cls = C_LOAD;
      end
      OP_STORE: begin
        if (funct3 <= 3'b010) cls = C_STORE;
        else                  cls = C_ILL;
      end
`ifdef MULTICYCLE_BRANCH_EN
      OP_BRANCH: begin
        cls = C_BRANCH;
        case (funct3)
          3'b000: begin alu_code = ALU_SUB;  br_taken =  bus.alu_zero; end
          3'b001: begin alu_code = ALU_SUB;  br_taken = !bus.alu_zero; end
          3'b100: begin alu_code = ALU_SLT;  br_taken =  bus.alu_lsb;  end
          3'b101: begin alu_code = ALU_SLT;  br_taken = !bus.alu_lsb;  end
          3'b110: begin alu_code = ALU_SLTU; br_taken =  bus.alu_lsb;  end
          3'b111: begin alu_code = ALU_SLTU; br_taken = !bus.alu_lsb;  end
          default: cls = C_ILL;
        endcase
      end
`endif
      default: cls = C_ILL;
    endcase
  end

  // Count never exceeds TIMEOUT-1 (<= 254), so the increment cannot wrap.
  assign wait_inc     = wait_cnt_q + CNT_W'(1);
  assign wait_expired = (wait_inc == CNT_W'(TIMEOUT));

  // State, wait counter and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      fault_q    <= fault_d;
    end
  end

  // Next state; the counter is zero unless waiting in FETCH/MEM, so every
  // entry into those states starts a fresh count.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    illegal_d  = illegal_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_R, C_I:         state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          C_BRANCH:         state_d = S_FETCH;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          state_d = (cls == C_STORE) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_d = S_TRAP;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  // Moore outputs; ready only qualifies the IR load and the store's PC update.
  always_comb begin
    alu_c      = ALU_ADD;
    regwe_c    = 1'b0;
    dmemwe_c   = 1'b0;
    regsel_c   = 1'b0;
    rs2sel_c   = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        ir_we_c    = bus.imem_ready;
      end
      S_EXEC: begin
        alu_c    = alu_code;
        rs2sel_c = (cls == C_I) || (cls == C_LOAD) || (cls == C_STORE);
        if (cls == C_BRANCH) begin
          pc_we_c  = 1'b1;
          pc_sel_c = br_taken;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        rs2sel_c   = 1'b1;
        dmemwe_c   = (cls == C_STORE);
        pc_we_c    = (cls == C_STORE) && bus.dmem_ready;
      end
      S_WB: begin
        regwe_c  = 1'b1;
        pc_we_c  = 1'b1;
        regsel_c = (cls == C_LOAD);
      end
      default: ;
    endcase
  end

  assign bus.ALUControl = ALUCTL_W'(alu_c);
  assign bus.regwe      = regwe_c;
  assign bus.dmemwe     = dmemwe_c;
  assign bus.regsel     = regsel_c;
  assign bus.rs2sel     = rs2sel_c;
  assign bus.imem_req   = imem_req_c;
  assign bus.dmem_req   = dmem_req_c;
  assign bus.ir_we      = ir_we_c;
  assign bus.pc_we      = pc_we_c;
`ifdef MULTICYCLE_BRANCH_EN
  assign bus.pc_sel     = pc_sel_c;
`else
  assign bus.pc_sel     = 1'b0;
`endif
  assign bus.illegal    = illegal_q;
  assign bus.fault      = fault_q;

endmodule
